cronometro_bcd_lap: RTL and testbench

//  Parametrised stopwatch core: free-running BCD chain (cent units upward) with start/stop, clear, lap.

---
 rtl/cronometro_bcd_lap_if.sv | 35 +++
 rtl/cronometro_bcd_lap.sv | 138 +++++++++++++
 tb/tb_cronometro_bcd_lap.sv | 277 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/cronometro_bcd_lap_if.sv
// Stopwatch control/display bundle: mode enable, button pulses from the
// debouncers and the packed BCD display value with status flags.
interface cronometro_bcd_lap_if #(
    parameter int N_DIGITS = 6
);
    logic                    modo_cronometro;
    logic                    btn_start_stop;
    logic                    btn_clear;
    logic                    btn_lap;
    logic [4*N_DIGITS-1:0]   digits_out;
    logic                    running;
    logic                    overflow;

    // Controller side: drives mode and buttons, reads the display
    modport master (
        output modo_cronometro,
        output btn_start_stop,
        output btn_clear,
        output btn_lap,
        input  digits_out,
        input  running,
        input  overflow
    );

    // Stopwatch core side
    modport slave (
        input  modo_cronometro,
        input  btn_start_stop,
        input  btn_clear,
        input  btn_lap,
        output digits_out,
        output running,
        output overflow
    );
endinterface

// File: rtl/cronometro_bcd_lap.sv
// Stopwatch core: 100 Hz prescaler feeding a BCD chain (cent units upward)
// with start/stop, clear and lap-freeze of the display.
// Build option: define CRONO_LAP_EN to enable the LAP state and btn_lap;
// without it btn_lap is ignored and the display always shows the live count.
module cronometro_bcd_lap #(
    parameter int CLK_HZ   = 50_000_000,
    parameter int N_DIGITS = 6
) (
    input  logic                 clk,
    input  logic                 rst_n,
    cronometro_bcd_lap_if.slave  bus
);

    localparam int PRESC_CNT = CLK_HZ / 100;
    localparam int PW        = $clog2(PRESC_CNT);
    localparam logic [PW-1:0] PRESC_MAX = PW'(PRESC_CNT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_STOP,
        S_LAP
    } state_t;

    state_t                 state_q, state_d;
    logic [PW-1:0]          presc_q, presc_d;
    logic [4*N_DIGITS-1:0]  count_q, count_d;
    logic [4*N_DIGITS-1:0]  disp_q, disp_d;
    logic                   overflow_q, overflow_d;
    logic                   running_q, running_d;
    logic                   counting;
    logic                   tick;
    logic                   carry;

    // Tens-of-seconds and tens-of-minutes style digits wrap at 5, others at 9
    function automatic logic [3:0] digit_max(input int i);
        return ((i % 2 == 1) && (i >= 3)) ? 4'd5 : 4'd9;
    endfunction

`ifndef CRONO_LAP_EN
    logic unused_btn_lap;
    assign unused_btn_lap = bus.btn_lap;
`endif

    // Next-state: mode low forces IDLE; start beats lap beats clear
    always_comb begin
        state_d = state_q;
        if (!bus.modo_cronometro) begin
            state_d = S_IDLE;
        end else if (bus.btn_start_stop) begin
            case (state_q)
                S_IDLE:  state_d = S_RUN;
                S_RUN:   state_d = S_STOP;
                S_STOP:  state_d = S_RUN;
                S_LAP:   state_d = S_STOP;
                default: state_d = S_IDLE;
            endcase
`ifdef CRONO_LAP_EN
        end else if (bus.btn_lap) begin
            if (state_q == S_RUN) begin
                state_d = S_LAP;
            end else if (state_q == S_LAP) begin
                state_d = S_RUN;
            end
`endif
        end else if (bus.btn_clear && (state_q == S_STOP)) begin
            state_d = S_IDLE;
        end
    end

    // Prescaler and BCD ripple chain; anything headed to IDLE is zeroed
    always_comb begin
        counting   = (state_q == S_RUN) || (state_q == S_LAP);
        tick       = counting && (presc_q == PRESC_MAX);
        presc_d    = presc_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        carry      = tick;
        if (counting) begin
            presc_d = tick ? '0 : presc_q + PW'(1);
        end
        for (int i = 0; i < N_DIGITS; i++) begin
            if (carry) begin
                if (count_q[4*i +: 4] >= digit_max(i)) begin
                    count_d[4*i +: 4] = 4'd0;
                end else begin
                    count_d[4*i +: 4] = count_q[4*i +: 4] + 4'd1;
                    carry             = 1'b0;
                end
            end
        end
        if (carry) begin
            overflow_d = 1'b1;
        end
        if (state_d == S_IDLE) begin
            presc_d    = '0;
            count_d    = '0;
            overflow_d = 1'b0;
        end
    end

    // Display follows the count one clock late, except while lap holds it
    always_comb begin
        disp_d    = count_q;
        running_d = (state_d == S_RUN) || (state_d == S_LAP);
        if (!bus.modo_cronometro) begin
            disp_d = '0;
`ifdef CRONO_LAP_EN
        end else if ((state_q == S_LAP) && (state_d == S_LAP)) begin
            disp_d = disp_q;
`endif
        end
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            presc_q    <= '0;
            count_q    <= '0;
            disp_q     <= '0;
            overflow_q <= 1'b0;
            running_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            presc_q    <= presc_d;
            count_q    <= count_d;
            disp_q     <= disp_d;
            overflow_q <= overflow_d;
            running_q  <= running_d;
        end
    end

    assign bus.digits_out = disp_q;
    assign bus.running    = running_q;
    assign bus.overflow   = overflow_q;

endmodule

// File: tb/tb_cronometro_bcd_lap.sv
// Bench for cronometro_bcd_lap: two instances (6 digits at 10 clk/tick and
// 4 digits at 2 clk/tick) share one stimulus and are compared every cycle
// against a centisecond-count reference model, plus directed spot values.
module tb_cronometro_bcd_lap;

    localparam int CLK_A = 1000;
    localparam int ND_A  = 6;
    localparam int CLK_B = 200;
    localparam int ND_B  = 4;

    localparam int M_IDLE = 0;
    localparam int M_RUN  = 1;
    localparam int M_STOP = 2;
    localparam int M_LAP  = 3;

`ifdef CRONO_LAP_EN
    localparam bit LAP_ON = 1'b1;
`else
    localparam bit LAP_ON = 1'b0;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    int nChecks = 0;
    int nFails  = 0;

    int tickLen[2]  = '{CLK_A / 100, CLK_B / 100};
    int totalCnt[2] = '{360000, 6000};
    int mMode[2];
    int mTicks[2];
    int mPhase[2];
    int mDisp[2];
    bit mOvf[2];
    bit mRun[2];

    cronometro_bcd_lap_if #(.N_DIGITS(ND_A)) ifA ();
    cronometro_bcd_lap_if #(.N_DIGITS(ND_B)) ifB ();

    cronometro_bcd_lap #(.CLK_HZ(CLK_A), .N_DIGITS(ND_A)) dutA (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifA)
    );

    cronometro_bcd_lap #(.CLK_HZ(CLK_B), .N_DIGITS(ND_B)) dutB (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifB)
    );

    always #5 clk = ~clk;

    // Centisecond total -> packed BCD using the mixed 10/6 radix
    function automatic logic [31:0] toBcd(input int v, input int nd);
        logic [31:0] r;
        int x;
        r = '0;
        x = v;
        for (int i = 0; i < nd; i++) begin
            int m;
            m = ((i % 2 == 1) && (i >= 3)) ? 6 : 10;
            r[4*i +: 4] = 4'(x % m);
            x = x / m;
        end
        return r;
    endfunction

    function automatic int nextMode(input int m, input bit ss, input bit clr, input bit lp);
        if (ss) begin
            if (m == M_IDLE || m == M_STOP) return M_RUN;
            return M_STOP;
        end
        if (lp && LAP_ON) begin
            if (m == M_RUN) return M_LAP;
            if (m == M_LAP) return M_RUN;
            return m;
        end
        if (clr && m == M_STOP) return M_IDLE;
        return m;
    endfunction

    function automatic void modelReset();
        for (int k = 0; k < 2; k++) begin
            mMode[k]  = M_IDLE;
            mTicks[k] = 0;
            mPhase[k] = 0;
            mDisp[k]  = 0;
            mOvf[k]   = 1'b0;
            mRun[k]   = 1'b0;
        end
    endfunction

    // One clock edge of the reference stopwatch
    function automatic void modelEdge(input int k, input bit ss, input bit clr,
                                      input bit lp, input bit md);
        int oldTicks;
        int nxt;
        if (!md) begin
            mMode[k]  = M_IDLE;
            mTicks[k] = 0;
            mPhase[k] = 0;
            mDisp[k]  = 0;
            mOvf[k]   = 1'b0;
            mRun[k]   = 1'b0;
        end else begin
            oldTicks = mTicks[k];
            if (mMode[k] == M_RUN || mMode[k] == M_LAP) begin
                mPhase[k]++;
                if (mPhase[k] == tickLen[k]) begin
                    mPhase[k] = 0;
                    mTicks[k] = (mTicks[k] + 1) % totalCnt[k];
                    if (mTicks[k] == 0) mOvf[k] = 1'b1;
                end
            end
            nxt = nextMode(mMode[k], ss, clr, lp);
            if (nxt == M_IDLE) begin
                mTicks[k] = 0;
                mPhase[k] = 0;
                mOvf[k]   = 1'b0;
            end
            if (!(mMode[k] == M_LAP && nxt == M_LAP)) mDisp[k] = oldTicks;
            mRun[k]  = (nxt == M_RUN || nxt == M_LAP);
            mMode[k] = nxt;
        end
    endfunction

    task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nChecks++;
        assert (obs === exp) else begin
            nFails++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic checkOutput();
        checkVal("digits_a",   32'(ifA.digits_out), toBcd(mDisp[0], ND_A));
        checkVal("running_a",  32'(ifA.running),    32'(mRun[0]));
        checkVal("overflow_a", 32'(ifA.overflow),   32'(mOvf[0]));
        checkVal("digits_b",   32'(ifB.digits_out), toBcd(mDisp[1], ND_B));
        checkVal("running_b",  32'(ifB.running),    32'(mRun[1]));
        checkVal("overflow_b", 32'(ifB.overflow),   32'(mOvf[1]));
    endtask

    task automatic applyStimulus(input bit ss, input bit clr, input bit lp, input bit md);
        ifA.btn_start_stop  = ss;
        ifA.btn_clear       = clr;
        ifA.btn_lap         = lp;
        ifA.modo_cronometro = md;
        ifB.btn_start_stop  = ss;
        ifB.btn_clear       = clr;
        ifB.btn_lap         = lp;
        ifB.modo_cronometro = md;
    endtask

    // Called at a negedge: check, drive, clock, advance model, clear pulses
    task automatic runCycle(input bit ss, input bit clr, input bit lp, input bit md);
        checkOutput();
        applyStimulus(ss, clr, lp, md);
        @(posedge clk);
        modelEdge(0, ss, clr, lp, md);
        modelEdge(1, ss, clr, lp, md);
        #1;
        applyStimulus(1'b0, 1'b0, 1'b0, md);
        @(negedge clk);
    endtask

    task automatic idle(input int n, input bit md);
        for (int i = 0; i < n; i++) runCycle(1'b0, 1'b0, 1'b0, md);
    endtask

    initial begin
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
        modelReset();
        #12;
        checkVal("rst_digits_a", 32'(ifA.digits_out), 32'h0);
        checkVal("rst_running_a", 32'(ifA.running), 32'h0);
        checkVal("rst_overflow_b", 32'(ifB.overflow), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        idle(3, 1'b1);

        $display("[TB] run 100 ticks");
        runCycle(1'b1, 1'b0, 1'b0, 1'b1);
        idle(1001, 1'b1);
        checkVal("t1_digits_a", 32'(ifA.digits_out), 32'h000100);
        checkVal("t1_running_a", 32'(ifA.running), 32'h1);

        $display("[TB] clear while running, then stop and clear");
        runCycle(1'b0, 1'b1, 1'b0, 1'b1);
        idle($urandom_range(20, 200), 1'b1);
        runCycle(1'b1, 1'b0, 1'b0, 1'b1);
        idle(3, 1'b1);
        runCycle(1'b0, 1'b1, 1'b0, 1'b1);
        idle(2, 1'b1);
        checkVal("clr_digits_a", 32'(ifA.digits_out), 32'h0);
        checkVal("clr_running_a", 32'(ifA.running), 32'h0);

        $display("[TB] stop at 00.40");
        runCycle(1'b1, 1'b0, 1'b0, 1'b1);
        idle(399, 1'b1);
        runCycle(1'b1, 1'b0, 1'b0, 1'b1);
        idle(2, 1'b1);
        checkVal("t4_digits_a", 32'(ifA.digits_out), 32'h000040);
        runCycle(1'b0, 1'b1, 1'b0, 1'b1);
        idle(2, 1'b1);
        checkVal("t4_clear_a", 32'(ifA.digits_out), 32'h0);

        $display("[TB] overflow on 4-digit instance");
        runCycle(1'b1, 1'b0, 1'b0, 1'b1);
        idle(12000, 1'b1);
        checkVal("pre_wrap_b", 32'(ifB.digits_out), 32'h5999);
        idle(1, 1'b1);
        checkVal("wrap_digits_b", 32'(ifB.digits_out), 32'h0);
        checkVal("wrap_overflow_b", 32'(ifB.overflow), 32'h1);
        checkVal("wrap_digits_a", 32'(ifA.digits_out), 32'h001200);
        runCycle(1'b1, 1'b0, 1'b0, 1'b1);
        idle(2, 1'b1);
        checkVal("sticky_overflow_b", 32'(ifB.overflow), 32'h1);
        runCycle(1'b0, 1'b1, 1'b0, 1'b1);
        idle(2, 1'b1);
        checkVal("cleared_overflow_b", 32'(ifB.overflow), 32'h0);

        $display("[TB] lap freeze and release");
        runCycle(1'b1, 1'b0, 1'b0, 1'b1);
        idle(250, 1'b1);
        runCycle(1'b0, 1'b0, 1'b1, 1'b1);
        idle(300, 1'b1);
        checkVal("lap_hold_a", 32'(ifA.digits_out), LAP_ON ? 32'h000025 : 32'h000055);
        checkVal("lap_running_a", 32'(ifA.running), 32'h1);
        runCycle(1'b0, 1'b0, 1'b1, 1'b1);
        idle(1, 1'b1);
        checkVal("lap_release_a", 32'(ifA.digits_out), 32'h000055);

        $display("[TB] start+lap together, then mode drop");
        runCycle(1'b1, 1'b0, 1'b1, 1'b1);
        idle(2, 1'b1);
        checkVal("t5_running_a", 32'(ifA.running), 32'h0);
        runCycle(1'b1, 1'b0, 1'b0, 1'b1);
        idle(37, 1'b1);
        runCycle(1'b0, 1'b0, 1'b0, 1'b0);
        checkVal("mode_digits_a", 32'(ifA.digits_out), 32'h0);
        checkVal("mode_running_a", 32'(ifA.running), 32'h0);
        runCycle(1'b1, 1'b0, 1'b0, 1'b0);
        idle(3, 1'b0);
        idle(3, 1'b1);
        checkVal("mode_reenable_a", 32'(ifA.running), 32'h0);

        $display("[TB] random pulses");
        for (int i = 0; i < 3000; i++) begin
            int r;
            r = int'($urandom_range(0, 199));
            runCycle(r < 4, (r >= 8) && (r < 12), (r >= 4) && (r < 8), r != 199);
        end

        $display("[TB] asynchronous reset mid-run");
        runCycle(1'b1, 1'b0, 1'b0, 1'b1);
        idle(57, 1'b1);
        #3;
        rst_n = 1'b0;
        #1;
        modelReset();
        checkVal("arst_digits_a", 32'(ifA.digits_out), 32'h0);
        checkVal("arst_running_a", 32'(ifA.running), 32'h0);
        checkVal("arst_digits_b", 32'(ifB.digits_out), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        idle(5, 1'b1);
        runCycle(1'b1, 1'b0, 1'b0, 1'b1);
        idle(40, 1'b1);
        checkOutput();

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
